// File: rtl/uart_sim_pkg.sv
// ---------------------------------------------------------------------------
// uart_sim_pkg
// Shared definitions for the UART simulation pattern monitor:
//   - parity mode constants (none / odd / even)
//   - receive FSM state encoding
//   - baud divider helpers (full bit period and half bit period in clocks)
// ---------------------------------------------------------------------------
package uart_sim_pkg;

  // Parity modes, matched against the PARITY parameter of the monitor
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Receive FSM states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } rx_state_e;

  // Clock cycles per bit, integer floor
  function automatic int calc_div(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Clock cycles from the start edge to the middle of the start bit
  function automatic int calc_half(input int clock_freq, input int baud_rate);
    return calc_div(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_sim_rx_core.sv
// ---------------------------------------------------------------------------
// uart_sim_rx_core
// UART frame receiver: 2-FF input synchroniser, falling-edge start detect,
// baud counter and IDLE/START/DATA/PAR/STOP FSM.
//
// Ports:
//   clk_i         system clock
//   rstn_i        asynchronous active-low reset
//   txd_i         serial line under observation, idle high
//   data_o        last received character, zero-extended above DATA_BITS
//   valid_o       one-cycle pulse when data_o updates
//   frame_err_o   one-cycle pulse with valid_o when the stop bit was low
//   parity_err_o  one-cycle pulse with valid_o on parity mismatch
// ---------------------------------------------------------------------------
module uart_sim_rx_core
  import uart_sim_pkg::*;
#(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       txd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o
);

  localparam int DIV   = calc_div(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF  = calc_half(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W = $clog2(DIV + 1);

  // The counter expires when it reaches zero, so a reload of N-1 gives an
  // interval of exactly N clocks between samples.
  localparam logic [CNT_W-1:0] DIV_RELOAD  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF - 1);
  localparam logic [3:0]       LAST_BIT    = 4'(DATA_BITS - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             prev_q;
  logic             rx_bit;
  logic             fall_edge;
  logic             tick;

  rx_state_e        state_q;
  rx_state_e        state_d;
  logic [CNT_W-1:0] baud_q;
  logic [CNT_W-1:0] baud_d;
  logic [3:0]       bit_q;
  logic [3:0]       bit_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             perr_q;
  logic             perr_d;
  logic [7:0]       data_d;
  logic             valid_d;
  logic             ferr_out_d;
  logic             perr_out_d;

  // Synchroniser and previous-sample flop reset to the idle line level so
  // that reset release never looks like a start edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync_q1 <= txd_i;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign rx_bit    = sync_q2;
  assign fall_edge = prev_q & ~sync_q2;
  assign tick      = (baud_q == '0);

  // Next-state logic. The counter free-runs down to zero and holds there;
  // every sampling state reloads it on its tick. Outputs other than data_o
  // default to zero so the result flags are single-cycle pulses.
  always_comb begin
    state_d    = state_q;
    baud_d     = tick ? baud_q : (baud_q - CNT_W'(1));
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    data_d     = data_o;
    valid_d    = 1'b0;
    ferr_out_d = 1'b0;
    perr_out_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d = START;
          baud_d  = HALF_RELOAD;
        end
      end

      START: begin
        if (tick) begin
          if (!rx_bit) begin
            state_d = DATA;
            baud_d  = DIV_RELOAD;
            bit_d   = 4'd0;
            shift_d = 8'h00;
            perr_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (tick) begin
          shift_d[bit_q[2:0]] = rx_bit;
          baud_d              = DIV_RELOAD;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      PAR: begin
        if (tick) begin
          baud_d  = DIV_RELOAD;
          state_d = STOP;
          if (PARITY == PAR_ODD) begin
            perr_d = ~(^shift_q ^ rx_bit);
          end else begin
            perr_d = ^shift_q ^ rx_bit;
          end
        end
      end

      STOP: begin
        if (tick) begin
          state_d    = IDLE;
          valid_d    = 1'b1;
          data_d     = shift_q;
          ferr_out_d = ~rx_bit;
          perr_out_d = perr_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, including the registered result outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= 4'd0;
      shift_q      <= 8'h00;
      perr_q       <= 1'b0;
      data_o       <= 8'h00;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      data_o       <= data_d;
      valid_o      <= valid_d;
      frame_err_o  <= ferr_out_d;
      parity_err_o <= perr_out_d;
    end
  end

endmodule

// File: rtl/uart_sim_pattern_monitor.sv
// ---------------------------------------------------------------------------
// uart_sim_pattern_monitor
// UART receive monitor with expected-string matcher, character counter and
// no-match timeout, giving a bench a single sticky pass/fail indication.
//
// Ports:
//   clk_i         system clock
//   rstn_i        asynchronous active-low reset
//   txd_i         serial line under observation, idle high
//   clr_i         synchronous clear of sticky flags, counter, window, timeout
//   data_o        last received character
//   valid_o       one-cycle pulse when data_o updates
//   frame_err_o   pulse with valid_o when the stop bit was low
//   parity_err_o  pulse with valid_o on parity mismatch
//   match_o       sticky, expected string has been received
//   timeout_o     sticky, TIMEOUT_CYCLES elapsed without a match
//   char_cnt_o    characters received, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module uart_sim_pattern_monitor
  import uart_sim_pkg::*;
#(
  parameter int                       CLOCK_FREQ     = 100000000,
  parameter int                       BAUD_RATE      = 19200,
  parameter int                       DATA_BITS      = 8,
  parameter int                       PARITY         = 0,
  parameter int                       PATTERN_LEN    = 7,
  parameter logic [8*PATTERN_LEN-1:0] PATTERN        = "NEORV32",
  parameter int                       TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        txd_i,
  input  logic        clr_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  output logic        frame_err_o,
  output logic        parity_err_o,
  output logic        match_o,
  output logic        timeout_o,
  output logic [15:0] char_cnt_o
);

  localparam int          WIN_W    = 8 * PATTERN_LEN;
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] win_shifted;
  logic [WIN_W-1:0] win_next;
  logic [31:0]      to_cnt_q;
  logic [31:0]      to_cnt_inc;
  logic             char_err;
  logic             match_set;
  logic             to_run;
  logic             timeout_hit;

  uart_sim_rx_core #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .DATA_BITS  (DATA_BITS),
    .PARITY     (PARITY)
  ) u_rx_core (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .txd_i        (txd_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o)
  );

  // Window and match decode. The match is taken from the window value about
  // to be written so match_o rises together with the window update, one
  // cycle after valid_o. An errored character empties the window, so a
  // corrupted stream can never complete the string across the error.
  always_comb begin
    char_err    = frame_err_o | parity_err_o;
    win_shifted = (win_q << 8) | WIN_W'(data_o);
    win_next    = char_err ? '0 : win_shifted;
    match_set   = valid_o && !clr_i && (win_next == PATTERN);
  end

  // Timeout decode. Counting stops once matched or timed out; a match
  // landing on the threshold cycle suppresses the timeout.
  always_comb begin
    to_cnt_inc  = to_cnt_q + 32'd1;
    to_run      = (TIMEOUT_CYCLES != 0) && !match_o && !match_set && !timeout_o;
    timeout_hit = to_run && (to_cnt_inc == TO_LIMIT);
  end

  // Character counter, match window and sticky match flag. clr_i takes
  // precedence over a valid_o arriving in the same cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      char_cnt_o <= 16'h0000;
      win_q      <= '0;
      match_o    <= 1'b0;
    end else if (clr_i) begin
      char_cnt_o <= 16'h0000;
      win_q      <= '0;
      match_o    <= 1'b0;
    end else if (valid_o) begin
      if (char_cnt_o != 16'hFFFF) begin
        char_cnt_o <= char_cnt_o + 16'd1;
      end
      win_q <= win_next;
      if (match_set) begin
        match_o <= 1'b1;
      end
    end
  end

  // No-match timeout counter and sticky timeout flag
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      to_cnt_q  <= 32'd0;
      timeout_o <= 1'b0;
    end else if (clr_i) begin
      to_cnt_q  <= 32'd0;
      timeout_o <= 1'b0;
    end else begin
      if (to_run) begin
        to_cnt_q <= to_cnt_inc;
      end
      if (timeout_hit) begin
        timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_sim_pattern_monitor.sv
// ---------------------------------------------------------------------------
// tb_uart_sim_pattern_monitor
// Directed bench for the UART pattern monitor. A fast clock/baud pair gives
// 16 clocks per bit. Four instances: main (8N1, no timeout), even and odd
// parity receivers sharing one line, and a timeout instance on an idle line.
// ---------------------------------------------------------------------------
module tb_uart_sim_pattern_monitor;

  localparam int CLK_FREQ_TB = 1600000;
  localparam int BAUD_TB     = 100000;
  localparam int BIT_CYC     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_main;
  logic rstn_to;
  logic clr_main;
  logic clr_off;
  logic txd_main;
  logic txd_par;
  logic txd_idle;

  logic [7:0]  m_data;
  logic        m_valid, m_ferr, m_perr, m_match, m_timeout;
  logic [15:0] m_cnt;

  logic [7:0]  e_data;
  logic        e_valid, e_ferr, e_perr, e_match, e_timeout;
  logic [15:0] e_cnt;

  logic [7:0]  o_data;
  logic        o_valid, o_ferr, o_perr, o_match, o_timeout;
  logic [15:0] o_cnt;

  logic [7:0]  t_data;
  logic        t_valid, t_ferr, t_perr, t_match, t_timeout;
  logic [15:0] t_cnt;

  uart_sim_pattern_monitor #(
    .CLOCK_FREQ (CLK_FREQ_TB), .BAUD_RATE (BAUD_TB), .DATA_BITS (8),
    .PARITY (0), .TIMEOUT_CYCLES (0)
  ) dut_main (
    .clk_i (clk), .rstn_i (rstn_main), .txd_i (txd_main), .clr_i (clr_main),
    .data_o (m_data), .valid_o (m_valid), .frame_err_o (m_ferr),
    .parity_err_o (m_perr), .match_o (m_match), .timeout_o (m_timeout),
    .char_cnt_o (m_cnt)
  );

  uart_sim_pattern_monitor #(
    .CLOCK_FREQ (CLK_FREQ_TB), .BAUD_RATE (BAUD_TB), .DATA_BITS (8),
    .PARITY (2), .TIMEOUT_CYCLES (0)
  ) dut_even (
    .clk_i (clk), .rstn_i (rstn_main), .txd_i (txd_par), .clr_i (clr_off),
    .data_o (e_data), .valid_o (e_valid), .frame_err_o (e_ferr),
    .parity_err_o (e_perr), .match_o (e_match), .timeout_o (e_timeout),
    .char_cnt_o (e_cnt)
  );

  uart_sim_pattern_monitor #(
    .CLOCK_FREQ (CLK_FREQ_TB), .BAUD_RATE (BAUD_TB), .DATA_BITS (8),
    .PARITY (1), .TIMEOUT_CYCLES (0)
  ) dut_odd (
    .clk_i (clk), .rstn_i (rstn_main), .txd_i (txd_par), .clr_i (clr_off),
    .data_o (o_data), .valid_o (o_valid), .frame_err_o (o_ferr),
    .parity_err_o (o_perr), .match_o (o_match), .timeout_o (o_timeout),
    .char_cnt_o (o_cnt)
  );

  uart_sim_pattern_monitor #(
    .CLOCK_FREQ (CLK_FREQ_TB), .BAUD_RATE (BAUD_TB), .DATA_BITS (8),
    .PARITY (0), .TIMEOUT_CYCLES (100)
  ) dut_to (
    .clk_i (clk), .rstn_i (rstn_to), .txd_i (txd_idle), .clr_i (clr_off),
    .data_o (t_data), .valid_o (t_valid), .frame_err_o (t_ferr),
    .parity_err_o (t_perr), .match_o (t_match), .timeout_o (t_timeout),
    .char_cnt_o (t_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Log of main-instance characters and the first cycle match_o was seen high
  int         cycle_num   = 0;
  int         match_cycle = -1;
  logic [7:0] log_data[$];
  logic       log_ferr[$];
  logic       log_perr[$];
  int         log_cycle[$];

  always @(negedge clk) begin
    cycle_num++;
    if (m_valid) begin
      log_data.push_back(m_data);
      log_ferr.push_back(m_ferr);
      log_perr.push_back(m_perr);
      log_cycle.push_back(cycle_num);
    end
    if (m_match && match_cycle < 0) begin
      match_cycle = cycle_num;
    end
  end

  // Last-character capture for the parity instances
  int         e_valids = 0;
  int         o_valids = 0;
  logic [7:0] e_last_data = 8'h00;
  logic [7:0] o_last_data = 8'h00;
  logic       e_last_perr = 1'b0;
  logic       o_last_perr = 1'b0;
  logic       e_last_ferr = 1'b0;

  always @(negedge clk) begin
    if (e_valid) begin
      e_valids++;
      e_last_data = e_data;
      e_last_perr = e_perr;
      e_last_ferr = e_ferr;
    end
    if (o_valid) begin
      o_valids++;
      o_last_data = o_data;
      o_last_perr = o_perr;
    end
  end

  function automatic logic [7:0] getData(input int i);
    if (i < log_data.size()) return log_data[i];
    return 8'h00;
  endfunction

  function automatic int getCycle(input int i);
    if (i >= 0 && i < log_cycle.size()) return log_cycle[i];
    return -100;
  endfunction

  function automatic int sumFerr();
    int s = 0;
    foreach (log_ferr[i]) s += int'(log_ferr[i]);
    return s;
  endfunction

  function automatic int sumPerr();
    int s = 0;
    foreach (log_perr[i]) s += int'(log_perr[i]);
    return s;
  endfunction

  task automatic clearLog();
    log_data.delete();
    log_ferr.delete();
    log_perr.delete();
    log_cycle.delete();
    match_cycle = -1;
  endtask

  task automatic driveBit(input bit par_line, input logic v);
    if (par_line) txd_par = v;
    else          txd_main = v;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  // One frame: start bit, 8 data bits LSB first, optional parity, stop, idle gap
  task automatic applyStimulus(input bit par_line, input logic [7:0] ch,
                               input bit use_par, input bit par_bit,
                               input bit stop_bit, input int gap_bits);
    driveBit(par_line, 1'b0);
    for (int b = 0; b < 8; b++) driveBit(par_line, ch[b]);
    if (use_par) driveBit(par_line, par_bit);
    driveBit(par_line, stop_bit);
    for (int g = 0; g < gap_bits; g++) driveBit(par_line, 1'b1);
  endtask

  task automatic sendString(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(1'b0, s[i], 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic pulseClr();
    @(negedge clk);
    clr_main = 1'b1;
    @(negedge clk);
    clr_main = 1'b0;
  endtask

  // Hang guard
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  string exp_str;
  int    n;

  initial begin
    rstn_main = 1'b0;
    rstn_to   = 1'b0;
    clr_main  = 1'b0;
    clr_off   = 1'b0;
    txd_main  = 1'b1;
    txd_par   = 1'b1;
    txd_idle  = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("rst_data",  m_data, 8'h00);
    checkOutput("rst_valid", m_valid, 1'b0);
    checkOutput("rst_match", m_match, 1'b0);
    checkOutput("rst_cnt",   m_cnt, 16'h0000);
    checkOutput("rst_errs",  {m_ferr, m_perr, m_timeout}, 3'b000);
    rstn_main = 1'b1;
    repeat (5) @(negedge clk);
    clearLog();

    // Test 1: plain pattern, back-to-back frames
    exp_str = "NEORV32";
    sendString(exp_str);
    repeat (BIT_CYC) @(negedge clk);
    checkOutput("t1_count", log_data.size(), 7);
    for (int i = 0; i < exp_str.len(); i++)
      checkOutput($sformatf("t1_data%0d", i), getData(i), exp_str[i]);
    checkOutput("t1_ferr", sumFerr(), 0);
    checkOutput("t1_perr", sumPerr(), 0);
    checkOutput("t1_match_cycle", match_cycle, getCycle(6) + 1);
    checkOutput("t1_cnt", m_cnt, 16'd7);

    pulseClr();
    @(negedge clk);
    checkOutput("clr_cnt",   m_cnt, 16'd0);
    checkOutput("clr_match", m_match, 1'b0);
    clearLog();

    // Test 2: overlapping prefix
    sendString("NENEORV32");
    repeat (BIT_CYC) @(negedge clk);
    checkOutput("t2_count", log_data.size(), 9);
    checkOutput("t2_match_cycle", match_cycle, getCycle(8) + 1);
    checkOutput("t2_cnt", m_cnt, 16'd9);
    pulseClr();
    clearLog();

    // Test 3: short low glitch (4 clocks < half bit) is rejected
    @(negedge clk);
    txd_main = 1'b0;
    repeat (4) @(negedge clk);
    txd_main = 1'b1;
    repeat (3 * BIT_CYC) @(negedge clk);
    checkOutput("t3_glitch_count", log_data.size(), 0);
    checkOutput("t3_glitch_cnt", m_cnt, 16'd0);
    applyStimulus(1'b0, 8'h56, 1'b0, 1'b0, 1'b1, 1);
    checkOutput("t3_after_count", log_data.size(), 1);
    checkOutput("t3_after_data", getData(0), 8'h56);
    checkOutput("t3_after_cnt", m_cnt, 16'd1);
    pulseClr();
    clearLog();

    // Test 4: framing error on 'R' flushes, then the full string matches
    applyStimulus(1'b0, 8'h4E, 1'b0, 1'b0, 1'b1, 0);
    applyStimulus(1'b0, 8'h45, 1'b0, 1'b0, 1'b1, 0);
    applyStimulus(1'b0, 8'h4F, 1'b0, 1'b0, 1'b1, 0);
    applyStimulus(1'b0, 8'h52, 1'b0, 1'b0, 1'b0, 2);
    sendString("NEORV32");
    repeat (BIT_CYC) @(negedge clk);
    checkOutput("t4_count", log_data.size(), 11);
    checkOutput("t4_bad_data", getData(3), 8'h52);
    n = (log_ferr.size() > 3) ? int'(log_ferr[3]) : 0;
    checkOutput("t4_bad_ferr", n, 1);
    checkOutput("t4_ferr_total", sumFerr(), 1);
    checkOutput("t4_perr_total", sumPerr(), 0);
    checkOutput("t4_match_cycle", match_cycle, getCycle(10) + 1);
    checkOutput("t4_cnt", m_cnt, 16'd11);

    // Test 5: 0x41 has two ones; parity bit 1 is odd-correct, even-wrong
    applyStimulus(1'b1, 8'h41, 1'b1, 1'b1, 1'b1, 1);
    checkOutput("t5_even_valids", e_valids, 1);
    checkOutput("t5_even_data", e_last_data, 8'h41);
    checkOutput("t5_even_perr", e_last_perr, 1'b1);
    checkOutput("t5_even_ferr", e_last_ferr, 1'b0);
    checkOutput("t5_odd_valids", o_valids, 1);
    checkOutput("t5_odd_data", o_last_data, 8'h41);
    checkOutput("t5_odd_perr", o_last_perr, 1'b0);
    applyStimulus(1'b1, 8'h41, 1'b1, 1'b0, 1'b1, 1);
    checkOutput("t5b_even_perr", e_last_perr, 1'b0);
    checkOutput("t5b_odd_perr", o_last_perr, 1'b1);
    checkOutput("t5b_even_cnt", e_cnt, 16'd2);

    // Test 6a: timeout exactly 100 clocks after reset release
    @(negedge clk);
    rstn_to = 1'b1;
    repeat (99) @(posedge clk);
    @(negedge clk);
    checkOutput("t6_timeout_99", t_timeout, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6_timeout_100", t_timeout, 1'b1);
    checkOutput("t6_main_no_timeout", m_timeout, 1'b0);

    // Test 6b: reset in the middle of a frame aborts it
    clearLog();
    fork
      applyStimulus(1'b0, 8'h56, 1'b0, 1'b0, 1'b1, 1);
      begin
        repeat (3 * BIT_CYC) @(negedge clk);
        rstn_main = 1'b0;
        @(negedge clk);
        checkOutput("t6_rst_data",  m_data, 8'h00);
        checkOutput("t6_rst_match", m_match, 1'b0);
        checkOutput("t6_rst_cnt",   m_cnt, 16'd0);
        checkOutput("t6_rst_valid", m_valid, 1'b0);
      end
    join
    checkOutput("t6_aborted_count", log_data.size(), 0);
    rstn_main = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 8'h4E, 1'b0, 1'b0, 1'b1, 1);
    checkOutput("t6_next_count", log_data.size(), 1);
    checkOutput("t6_next_data", getData(0), 8'h4E);
    checkOutput("t6_next_errs", sumFerr() + sumPerr(), 0);
    checkOutput("t6_next_cnt", m_cnt, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
